id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register that feeds the ALU. It latches decoded operands and control, and
//  translates ALUOp/funct into the 4-bit ALUctl. It applies EX/MEM and MEM/WB forwarding so
//  A/B drive the ALU directly, and flags load-use hazards to the hazard unit.
//  Stall holds the stage; flush inserts a bubble.
// PARAMETERS
//  DATA_W  32  operand/result width
//  RA_W    5   register-address width
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       synchronous active-low reset
//  stall          in   1       hold all stage registers
//  flush          in   1       replace next stage contents with bubble
//  id_valid       in   1       decode slot holds a real instruction
//  id_alu_op      in   2       00 add, 01 sub, 10 R-type(funct), 11 or
//  id_funct       in   6       R-type funct field
//  id_rs, id_rt   in   RA_W    source register numbers
//  id_wreg        in   RA_W    destination register (already rd/rt-selected)
//  id_rs_data     in   DATA_W  register-file read port 1
//  id_rt_data     in   DATA_W  register-file read port 2
//  id_imm         in   DATA_W  extended immediate
//  id_alusrc      in   1       1: B = imm
//  id_regwrite, id_memread, id_memwrite, id_memtoreg  in 1 each  control bits
//  exmem_regwrite in 1; exmem_wreg in RA_W; exmem_result in DATA_W   EX/MEM forward source
//  memwb_regwrite in 1; memwb_wreg in RA_W; memwb_result in DATA_W   MEM/WB forward source
//  ex_valid       out  1       stage holds a real instruction
//  ALUctl         out  4       ALU opcode
//  A, B           out  DATA_W  ALU operands (forwarded)
//  ex_store_data  out  DATA_W  forwarded rt value for stores
//  ex_wreg        out  RA_W    destination register
//  ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out 1 each
//  ex_illegal     out  1       R-type funct not supported
//  load_use       out  1       combinational hazard request to stall IF/ID
// BEHAVIOUR
//  - Register update priority per edge: !rst_n > flush > stall > load.
//  - Reset and flush both clear every register: valid/control/illegal 0, ALUctl 2, wreg/data 0.
//    After reset, A=B=ex_store_data=0 unless a forward condition hits.
//  - Stall (no flush): all registers keep their value. Forwarding muxes stay live.
//  - Load: capture ID inputs. ALUctl is decoded in ID and registered, so latency is 1 cycle.
//    If id_valid=0, capture as a bubble (controls forced 0).
//  - ALUctl decode: op00->2, op01->6, op11->1.
//  - op10 funct decode: 0x20->2, 0x22->6, 0x24->0, 0x25->1, 0x2A->7, 0x27->12.
//    Any other funct gives ALUctl 15, sets ex_illegal, and forces regwrite/memwrite to 0.
//  - Forwarding (combinational, per operand, for the registered rs/rt):
//    - If exmem_regwrite and exmem_wreg != 0 and exmem_wreg matches, use exmem_result.
//    - Else if memwb_regwrite and memwb_wreg != 0 and memwb_wreg matches, use memwb_result.
//    - Else use the registered reg-file data. EX/MEM wins when both match.
//    - Register 0 is never forwarded.
//  - Operands: A = fwd(rs). B = ex_alusrc ? ex_imm : fwd(rt). ex_store_data = fwd(rt) always.
//  - load_use = ex_valid & ex_memread & (ex_wreg != 0) & id_valid
//    & (ex_wreg == id_rs | ex_wreg == id_rt).
//    It is combinational, with no registered delay. The block does not self-stall.
//  - Simultaneous flush+stall: flush wins, so a bubble is loaded.
// TESTING
//  - Reset: rst_n=0 for 2 clk -> ex_valid=0, ALUctl=2, A=B=0, all controls 0.
//  - R-type sweep: op=10 with funct 20,22,24,25,2A,27, then 3F.
//    -> ALUctl 2,6,0,1,7,12 one cycle later. Funct 3F -> ALUctl 15, ex_illegal=1, ex_regwrite=0.
//  - Forward priority: ex_rs=5, exmem_wreg=5 (0xAAAA), memwb_wreg=5 (0xBBBB) -> A=0xAAAA.
//    Drop exmem_regwrite -> A=0xBBBB. rs=0 with both wreg=0 -> A=registered data.
//  - Immediate path: alusrc=1, imm=0x10, rt forwarded 0x55.
//    -> B=0x10, ex_store_data=0x55.
//  - Load-use: stage holds lw to r8, ID presents rt=8 -> load_use=1.
//    Same with ex_wreg=0 -> load_use=0.
//  - Stall 3 cycles with changing ID inputs -> outputs frozen.
//    Flush+stall together -> bubble next edge (ex_valid=0).

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register feeding the ALU. Latches decoded operands and
//   control, registers the 4-bit ALU opcode decoded from ALUOp/funct, applies
//   EX/MEM and MEM/WB forwarding so A/B can drive the ALU directly, and raises
//   a combinational load-use request for the hazard unit.
//
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   stall, flush          hold stage / load a bubble (flush wins)
//   id_*                  decoded instruction from the ID stage
//   exmem_*, memwb_*      forwarding sources (regwrite, dest reg, result)
//   ex_valid              stage holds a real instruction
//   ALUctl                registered ALU opcode
//   A, B                  forwarded ALU operands
//   ex_store_data         forwarded rt value for stores
//   ex_wreg, ex_*         destination register and control bits
//   ex_illegal            unsupported R-type funct captured
//   load_use              load in EX feeds the instruction in ID
// ---------------------------------------------------------------------------
module id_ex_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RA_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [1:0]        id_alu_op,
   input  logic [5:0]        id_funct,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic [RA_W-1:0]   id_wreg,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_alusrc,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              id_memtoreg,
   input  logic              exmem_regwrite,
   input  logic [RA_W-1:0]   exmem_wreg,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_regwrite,
   input  logic [RA_W-1:0]   memwb_wreg,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              ex_valid,
   output logic [3:0]        ALUctl,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [RA_W-1:0]   ex_wreg,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_memtoreg,
   output logic              ex_illegal,
   output logic              load_use
);

   typedef enum logic [3:0] {
      ALU_AND = 4'd0,
      ALU_OR  = 4'd1,
      ALU_ADD = 4'd2,
      ALU_SUB = 4'd6,
      ALU_SLT = 4'd7,
      ALU_NOR = 4'd12,
      ALU_BAD = 4'd15
   } alu_ctl_e;

   typedef struct packed {
      logic              valid;
      logic [3:0]        alu_ctl;
      logic              illegal;
      logic [RA_W-1:0]   rs;
      logic [RA_W-1:0]   rt;
      logic [RA_W-1:0]   wreg;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic              alusrc;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
      logic              memtoreg;
   } stage_t;

   // Reset/flush contents: everything zero except the ALU opcode, which
   // idles at ADD.
   function automatic stage_t stage_clear();
      stage_t s;
      s         = '0;
      s.alu_ctl = ALU_ADD;
      return s;
   endfunction

   // Operand forwarding: EX/MEM has priority over MEM/WB, r0 never forwards.
   function automatic logic [DATA_W-1:0] fwd(
      input logic [RA_W-1:0]   r,
      input logic [DATA_W-1:0] rf_data,
      input logic              em_we,
      input logic [RA_W-1:0]   em_reg,
      input logic [DATA_W-1:0] em_val,
      input logic              mw_we,
      input logic [RA_W-1:0]   mw_reg,
      input logic [DATA_W-1:0] mw_val
   );
      if (em_we && (em_reg != '0) && (em_reg == r)) begin
         return em_val;
      end else if (mw_we && (mw_reg != '0) && (mw_reg == r)) begin
         return mw_val;
      end
      return rf_data;
   endfunction

   stage_t   stage_q;
   stage_t   stage_d;
   alu_ctl_e dec_ctl;
   logic     dec_bad;

   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;

   // ALU control decode in ID so the registered opcode is ready in EX.
   always_comb begin
      dec_ctl = ALU_ADD;
      dec_bad = 1'b0;
      case (id_alu_op)
         2'b00: dec_ctl = ALU_ADD;
         2'b01: dec_ctl = ALU_SUB;
         2'b11: dec_ctl = ALU_OR;
         default: begin
            case (id_funct)
               6'h20: dec_ctl = ALU_ADD;
               6'h22: dec_ctl = ALU_SUB;
               6'h24: dec_ctl = ALU_AND;
               6'h25: dec_ctl = ALU_OR;
               6'h2A: dec_ctl = ALU_SLT;
               6'h27: dec_ctl = ALU_NOR;
               default: begin
                  dec_ctl = ALU_BAD;
                  dec_bad = 1'b1;
               end
            endcase
         end
      endcase
   end

   // Next-state: flush beats stall beats load. An invalid ID slot still
   // captures its fields but all control bits are forced off.
   always_comb begin
      stage_d = stage_q;
      if (flush) begin
         stage_d = stage_clear();
      end else if (!stall) begin
         stage_d.valid    = id_valid;
         stage_d.alu_ctl  = dec_ctl;
         stage_d.illegal  = id_valid & dec_bad;
         stage_d.rs       = id_rs;
         stage_d.rt       = id_rt;
         stage_d.wreg     = id_wreg;
         stage_d.rs_data  = id_rs_data;
         stage_d.rt_data  = id_rt_data;
         stage_d.imm      = id_imm;
         stage_d.alusrc   = id_alusrc;
         stage_d.regwrite = id_valid & id_regwrite & ~dec_bad;
         stage_d.memwrite = id_valid & id_memwrite & ~dec_bad;
         stage_d.memread  = id_valid & id_memread;
         stage_d.memtoreg = id_valid & id_memtoreg;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q <= stage_clear();
      end else begin
         stage_q <= stage_d;
      end
   end

   always_comb begin
      fwd_rs = fwd(stage_q.rs, stage_q.rs_data,
                   exmem_regwrite, exmem_wreg, exmem_result,
                   memwb_regwrite, memwb_wreg, memwb_result);
      fwd_rt = fwd(stage_q.rt, stage_q.rt_data,
                   exmem_regwrite, exmem_wreg, exmem_result,
                   memwb_regwrite, memwb_wreg, memwb_result);
   end

   assign A             = fwd_rs;
   assign B             = stage_q.alusrc ? stage_q.imm : fwd_rt;
   assign ex_store_data = fwd_rt;

   assign ex_valid    = stage_q.valid;
   assign ALUctl      = stage_q.alu_ctl;
   assign ex_wreg     = stage_q.wreg;
   assign ex_regwrite = stage_q.regwrite;
   assign ex_memread  = stage_q.memread;
   assign ex_memwrite = stage_q.memwrite;
   assign ex_memtoreg = stage_q.memtoreg;
   assign ex_illegal  = stage_q.illegal;

   assign load_use = stage_q.valid & stage_q.memread & (stage_q.wreg != '0)
                   & id_valid
                   & ((stage_q.wreg == id_rs) | (stage_q.wreg == id_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, id_valid;
   logic [1:0]  id_alu_op;
   logic [5:0]  id_funct;
   logic [4:0]  id_rs, id_rt, id_wreg;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_wreg, memwb_wreg;
   logic [31:0] exmem_result, memwb_result;
   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
   logic        ex_illegal, load_use;
   logic [3:0]  ALUctl;
   logic [31:0] A, B, ex_store_data;
   logic [4:0]  ex_wreg;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(32), .RA_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
      .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
      .exmem_regwrite(exmem_regwrite), .exmem_wreg(exmem_wreg), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_wreg(memwb_wreg), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ALUctl(ALUctl), .A(A), .B(B), .ex_store_data(ex_store_data),
      .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_illegal(ex_illegal),
      .load_use(load_use)
   );

   // Reference model: the instruction currently held in EX.
   typedef struct {
      logic        valid, illegal, alusrc, rw, mr, mw, mtr;
      logic [3:0]  ctl;
      logic [4:0]  rs, rt, wreg;
      logic [31:0] rsd, rtd, imm;
   } slot_t;

   slot_t m;

   logic [5:0] funct_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
   logic [3:0] ctl_tab   [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd12};

   function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                      output logic [3:0] ctl, output logic bad);
      bad = 1'b0;
      ctl = 4'd2;
      if (op == 2'd1) ctl = 4'd6;
      else if (op == 2'd3) ctl = 4'd1;
      else if (op == 2'd2) begin
         ctl = 4'd15;
         bad = 1'b1;
         for (int i = 0; i < 6; i++)
            if (funct_tab[i] == f) begin
               ctl = ctl_tab[i];
               bad = 1'b0;
            end
      end
   endfunction

   function automatic slot_t empty_slot();
      slot_t s;
      s = '{valid: 0, illegal: 0, alusrc: 0, rw: 0, mr: 0, mw: 0, mtr: 0,
            ctl: 4'd2, rs: 0, rt: 0, wreg: 0, rsd: 0, rtd: 0, imm: 0};
      return s;
   endfunction

   function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] rf);
      if (exmem_regwrite && exmem_wreg != 0 && exmem_wreg == r) return exmem_result;
      if (memwb_regwrite && memwb_wreg != 0 && memwb_wreg == r) return memwb_result;
      return rf;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: update the model with the inputs the DUT samples, then move
   // to the falling edge where outputs are compared.
   task automatic tick();
      logic [3:0] c;
      logic       bad;
      @(posedge clk);
      if (!rst_n || flush) m = empty_slot();
      else if (!stall) begin
         ref_decode(id_alu_op, id_funct, c, bad);
         m.valid   = id_valid;
         m.ctl     = c;
         m.illegal = id_valid && bad;
         m.rs = id_rs;  m.rt = id_rt;  m.wreg = id_wreg;
         m.rsd = id_rs_data;  m.rtd = id_rt_data;  m.imm = id_imm;
         m.alusrc = id_alusrc;
         m.rw  = id_valid && id_regwrite && !bad;
         m.mw  = id_valid && id_memwrite && !bad;
         m.mr  = id_valid && id_memread;
         m.mtr = id_valid && id_memtoreg;
      end
      @(negedge clk);
   endtask

   task automatic check_all(input string t);
      logic [31:0] frt;
      logic        lu;
      frt = ref_fwd(m.rt, m.rtd);
      lu  = m.valid && m.mr && m.wreg != 0 && id_valid && (m.wreg == id_rs || m.wreg == id_rt);
      chk({t, ".valid"},  32'(ex_valid),      32'(m.valid));
      chk({t, ".ALUctl"}, 32'(ALUctl),        32'(m.ctl));
      chk({t, ".A"},      A,                  ref_fwd(m.rs, m.rsd));
      chk({t, ".B"},      B,                  m.alusrc ? m.imm : frt);
      chk({t, ".store"},  ex_store_data,      frt);
      chk({t, ".wreg"},   32'(ex_wreg),       32'(m.wreg));
      chk({t, ".rw"},     32'(ex_regwrite),   32'(m.rw));
      chk({t, ".mr"},     32'(ex_memread),    32'(m.mr));
      chk({t, ".mw"},     32'(ex_memwrite),   32'(m.mw));
      chk({t, ".mtr"},    32'(ex_memtoreg),   32'(m.mtr));
      chk({t, ".ill"},    32'(ex_illegal),    32'(m.illegal));
      chk({t, ".lu"},     32'(load_use),      32'(lu));
   endtask

   task automatic clear_inputs();
      stall = 0; flush = 0; id_valid = 0; id_alu_op = 0; id_funct = 0;
      id_rs = 0; id_rt = 0; id_wreg = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
      id_alusrc = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
      exmem_regwrite = 0; exmem_wreg = 0; exmem_result = 0;
      memwb_regwrite = 0; memwb_wreg = 0; memwb_result = 0;
   endtask

   task automatic randomize_inputs();
      id_valid    = 1'($urandom_range(0, 3) != 0);
      id_alu_op   = 2'($urandom);
      id_funct    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : funct_tab[$urandom_range(0, 5)];
      id_rs       = 5'($urandom_range(0, 7));
      id_rt       = 5'($urandom_range(0, 7));
      id_wreg     = 5'($urandom_range(0, 7));
      id_rs_data  = $urandom;  id_rt_data = $urandom;  id_imm = $urandom;
      id_alusrc   = 1'($urandom);  id_regwrite = 1'($urandom);
      id_memread  = 1'($urandom);  id_memwrite = 1'($urandom);
      id_memtoreg = 1'($urandom);
      exmem_regwrite = 1'($urandom); exmem_wreg = 5'($urandom_range(0, 7));
      exmem_result   = $urandom;
      memwb_regwrite = 1'($urandom); memwb_wreg = 5'($urandom_range(0, 7));
      memwb_result   = $urandom;
   endtask

   initial begin
      m = empty_slot();
      clear_inputs();

      // Reset
      rst_n = 0;
      tick(); tick();
      check_all("reset");
      chk("reset.ALUctl2", 32'(ALUctl), 32'd2);
      chk("reset.A0", A, 32'd0);
      rst_n = 1;

      // R-type sweep including one unsupported funct
      for (int i = 0; i < 7; i++) begin
         id_valid = 1; id_alu_op = 2'b10; id_regwrite = 1;
         id_funct = (i < 6) ? funct_tab[i] : 6'h3F;
         tick();
         check_all("rtype");
         chk("rtype.ctl", 32'(ALUctl), (i < 6) ? 32'(ctl_tab[i]) : 32'd15);
      end
      chk("rtype.ill", 32'(ex_illegal), 32'd1);
      chk("rtype.rw0", 32'(ex_regwrite), 32'd0);

      // Forward priority
      clear_inputs();
      id_valid = 1; id_alu_op = 2'b00; id_rs = 5; id_rs_data = 32'h1234;
      tick();
      exmem_regwrite = 1; exmem_wreg = 5; exmem_result = 32'hAAAA;
      memwb_regwrite = 1; memwb_wreg = 5; memwb_result = 32'hBBBB;
      #1 check_all("fwd_em");
      chk("fwd_em.A", A, 32'hAAAA);
      exmem_regwrite = 0;
      #1 check_all("fwd_mw");
      chk("fwd_mw.A", A, 32'hBBBB);
      id_rs = 0; id_rs_data = 32'h77; exmem_regwrite = 1; exmem_wreg = 0; memwb_wreg = 0;
      tick();
      check_all("fwd_r0");
      chk("fwd_r0.A", A, 32'h77);

      // Immediate path
      clear_inputs();
      id_valid = 1; id_alusrc = 1; id_imm = 32'h10; id_rt = 3; id_rt_data = 32'h99;
      tick();
      exmem_regwrite = 1; exmem_wreg = 3; exmem_result = 32'h55;
      #1 check_all("imm");
      chk("imm.B", B, 32'h10);
      chk("imm.store", ex_store_data, 32'h55);

      // Load-use
      clear_inputs();
      id_valid = 1; id_memread = 1; id_memtoreg = 1; id_regwrite = 1; id_wreg = 8;
      tick();
      id_rs = 1; id_rt = 8;
      #1 check_all("lu_hit");
      chk("lu_hit.lu", 32'(load_use), 32'd1);
      id_wreg = 0; id_rt = 0;
      tick();
      check_all("lu_r0");
      chk("lu_r0.lu", 32'(load_use), 32'd0);

      // Stall three cycles with changing ID inputs
      clear_inputs();
      id_valid = 1; id_alu_op = 2'b01; id_wreg = 9; id_regwrite = 1; id_rs_data = 32'hCAFE;
      tick();
      for (int i = 0; i < 3; i++) begin
         randomize_inputs();
         exmem_regwrite = 0; memwb_regwrite = 0;
         stall = 1;
         tick();
         check_all("stall");
         chk("stall.wreg", 32'(ex_wreg), 32'd9);
         chk("stall.A", A, 32'hCAFE);
      end

      // Flush and stall together
      flush = 1; stall = 1; id_valid = 1;
      tick();
      check_all("flush_stall");
      chk("flush_stall.valid", 32'(ex_valid), 32'd0);

      // Randomized run
      for (int n = 0; n < 400; n++) begin
         randomize_inputs();
         rst_n = ($urandom_range(0, 49) != 0);
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 9) == 0);
         tick();
         check_all("rand");
         randomize_inputs();
         #1 check_all("rand_comb");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
